// File: rtl/rom_read_arbiter_pkg.sv
// rom_read_arbiter_pkg
// Shared types and constants for the two-master ROM read arbiter:
//   - AXI field widths used on both the master and slave side
//   - one-hot arbiter state encoding and its bit indices
//   - master select type and default ID tags
package rom_read_arbiter_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;

    localparam int IDLE_BIT = 0;
    localparam int ADDR_BIT = 1;
    localparam int DATA_BIT = 2;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ADDR = 3'b010,
        DATA = 3'b100
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_sel_t;

    localparam logic [3:0] DEF_M0_TAG = 4'h1;
    localparam logic [3:0] DEF_M1_TAG = 4'h2;

    localparam logic [AXI_LEN_BITS-1:0] LEN_ONE = 4'd1;

endpackage

// File: rtl/rom_read_arbiter_rr_arbiter_2.sv
// rr_arbiter_2
// Combinational two-way round-robin pick.
//   req[1:0]   : request per master (bit 0 = M0, bit 1 = M1)
//   last_grant : master served most recently
//   gnt        : chosen master (meaningful only when valid)
//   valid      : at least one request present
module rr_arbiter_2
    import rom_read_arbiter_pkg::*;
(
    input  logic [1:0]  req,
    input  master_sel_t last_grant,
    output master_sel_t gnt,
    output logic        valid
);

    // Pick the sole requester, or on a tie the master that was not served last.
    always_comb begin
        valid = |req;
        gnt   = M0;
        case (req)
            2'b01:   gnt = M0;
            2'b10:   gnt = M1;
            2'b11:   gnt = (last_grant == M0) ? M1 : M0;
            default: gnt = M0;
        endcase
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
// Shares one ROM AXI read slave port between an instruction master (M0) and a
// data master (M1). A grant is held for a complete burst and released on the
// RLAST handshake; the slave ARID carries the granted master's tag in its
// upper nibble. len_err is sticky and flags short/long bursts or wrong RID tags.
// Ports:
//   clk, rstn                 : clock, asynchronous active-low reset
//   AR*_M0/1, ARREADY_M0/1    : master read-address channels
//   R*_M0/1, RREADY_M0/1      : master read-data channels
//   AR*_S, ARREADY_S          : slave read-address channel
//   R*_S, RREADY_S            : slave read-data channel
//   len_err                   : sticky burst-integrity error
module rom_read_arbiter
    import rom_read_arbiter_pkg::*;
#(
    parameter logic [3:0] M0_TAG = DEF_M0_TAG,
    parameter logic [3:0] M1_TAG = DEF_M1_TAG
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [AXI_ID_BITS-1:0]   ARID_M0,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_M0,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_M0,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M0,
    input  logic [1:0]               ARBURST_M0,
    input  logic                     ARVALID_M0,
    output logic                     ARREADY_M0,
    output logic [AXI_ID_BITS-1:0]   RID_M0,
    output logic [AXI_DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]               RRESP_M0,
    output logic                     RLAST_M0,
    output logic                     RVALID_M0,
    input  logic                     RREADY_M0,
    input  logic [AXI_ID_BITS-1:0]   ARID_M1,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_M1,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_M1,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M1,
    input  logic [1:0]               ARBURST_M1,
    input  logic                     ARVALID_M1,
    output logic                     ARREADY_M1,
    output logic [AXI_ID_BITS-1:0]   RID_M1,
    output logic [AXI_DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]               RRESP_M1,
    output logic                     RLAST_M1,
    output logic                     RVALID_M1,
    input  logic                     RREADY_M1,
    output logic [AXI_IDS_BITS-1:0]  ARID_S,
    output logic [AXI_ADDR_BITS-1:0] ARADDR_S,
    output logic [AXI_LEN_BITS-1:0]  ARLEN_S,
    output logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
    output logic [1:0]               ARBURST_S,
    output logic                     ARVALID_S,
    input  logic                     ARREADY_S,
    input  logic [AXI_IDS_BITS-1:0]  RID_S,
    input  logic [AXI_DATA_BITS-1:0] RDATA_S,
    input  logic [1:0]               RRESP_S,
    input  logic                     RLAST_S,
    input  logic                     RVALID_S,
    output logic                     RREADY_S,
    output logic                     len_err
);

    arb_state_t                state_r, state_nx_s;
    master_sel_t               grant_r, last_grant_r, arb_gnt_s;
    logic                      arb_valid_s;
    logic [AXI_LEN_BITS-1:0]   len_r, beat_cnt_r, win_len_s;
    logic                      len_err_r;
    logic [3:0]                grant_tag_s;
    logic                      arvalid_sel_s, rready_sel_s, r_hs_s, ar_hs_s;

    rr_arbiter_2 u_rr (
        .req        ({ARVALID_M1, ARVALID_M0}),
        .last_grant (last_grant_r),
        .gnt        (arb_gnt_s),
        .valid      (arb_valid_s)
    );

    assign win_len_s     = (arb_gnt_s == M1) ? ARLEN_M1 : ARLEN_M0;
    assign grant_tag_s   = (grant_r == M1) ? M1_TAG : M0_TAG;
    assign arvalid_sel_s = (grant_r == M1) ? ARVALID_M1 : ARVALID_M0;
    assign rready_sel_s  = (grant_r == M1) ? RREADY_M1 : RREADY_M0;
    assign ar_hs_s       = state_r[ADDR_BIT] & arvalid_sel_s & ARREADY_S;
    assign r_hs_s        = state_r[DATA_BIT] & RVALID_S & rready_sel_s;
    assign len_err       = len_err_r;

    // Next-state decode and channel routing; everything not routed stays zero.
    always_comb begin
        state_nx_s = state_r;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        ARVALID_S  = 1'b0;
        ARID_S     = {AXI_IDS_BITS{1'b0}};
        ARADDR_S   = {AXI_ADDR_BITS{1'b0}};
        ARLEN_S    = {AXI_LEN_BITS{1'b0}};
        ARSIZE_S   = {AXI_SIZE_BITS{1'b0}};
        ARBURST_S  = 2'b00;
        RREADY_S   = 1'b0;
        RVALID_M0  = 1'b0;
        RID_M0     = {AXI_ID_BITS{1'b0}};
        RDATA_M0   = {AXI_DATA_BITS{1'b0}};
        RRESP_M0   = 2'b00;
        RLAST_M0   = 1'b0;
        RVALID_M1  = 1'b0;
        RID_M1     = {AXI_ID_BITS{1'b0}};
        RDATA_M1   = {AXI_DATA_BITS{1'b0}};
        RRESP_M1   = 2'b00;
        RLAST_M1   = 1'b0;
        case (1'b1)
            state_r[IDLE_BIT]: begin
                state_nx_s = arb_valid_s ? ADDR : IDLE;
            end
            state_r[ADDR_BIT]: begin
                ARVALID_S = arvalid_sel_s;
                if (grant_r == M1) begin
                    ARID_S     = {grant_tag_s, ARID_M1};
                    ARADDR_S   = ARADDR_M1;
                    ARLEN_S    = ARLEN_M1;
                    ARSIZE_S   = ARSIZE_M1;
                    ARBURST_S  = ARBURST_M1;
                    ARREADY_M1 = ARREADY_S;
                end else begin
                    ARID_S     = {grant_tag_s, ARID_M0};
                    ARADDR_S   = ARADDR_M0;
                    ARLEN_S    = ARLEN_M0;
                    ARSIZE_S   = ARSIZE_M0;
                    ARBURST_S  = ARBURST_M0;
                    ARREADY_M0 = ARREADY_S;
                end
                state_nx_s = ar_hs_s ? DATA : ADDR;
            end
            state_r[DATA_BIT]: begin
                RREADY_S = rready_sel_s;
                if (grant_r == M1) begin
                    RVALID_M1 = RVALID_S;
                    RID_M1    = RID_S[AXI_ID_BITS-1:0];
                    RDATA_M1  = RDATA_S;
                    RRESP_M1  = RRESP_S;
                    RLAST_M1  = RLAST_S;
                end else begin
                    RVALID_M0 = RVALID_S;
                    RID_M0    = RID_S[AXI_ID_BITS-1:0];
                    RDATA_M0  = RDATA_S;
                    RRESP_M0  = RRESP_S;
                    RLAST_M0  = RLAST_S;
                end
                state_nx_s = (r_hs_s && RLAST_S) ? IDLE : DATA;
            end
            default: begin
                // Any non-one-hot encoding recovers to IDLE.
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping, beat counter and sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            grant_r      <= M0;
            last_grant_r <= M1;
            len_r        <= {AXI_LEN_BITS{1'b0}};
            beat_cnt_r   <= {AXI_LEN_BITS{1'b0}};
            len_err_r    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (state_r[IDLE_BIT] && arb_valid_s) begin
                grant_r    <= arb_gnt_s;
                len_r      <= win_len_s;
                beat_cnt_r <= {AXI_LEN_BITS{1'b0}};
            end else if (r_hs_s) begin
                // Wraps modulo 2^AXI_LEN_BITS; only the RLAST compare judges it.
                beat_cnt_r <= beat_cnt_r + LEN_ONE;
                if (RLAST_S) begin
                    last_grant_r <= grant_r;
                end
            end
            // beat_cnt_r still holds the beats before this one, so a correct
            // burst shows beat_cnt_r == ARLEN on its final beat.
            if (r_hs_s && ((RLAST_S && (beat_cnt_r != len_r)) ||
                           (RID_S[AXI_IDS_BITS-1 -: 4] != grant_tag_s))) begin
                len_err_r <= 1'b1;
            end
        end
    end

endmodule
